mem_bank_nrw: RTL and testbench

- Parametrised N-port read/write register-file bank; successor to the fixed 2-port, 4x64 bank.
- Generalised width, depth and port count; byte write masks; registered reads with valid strobe.
- Deterministic write-collision arbitration with drop reporting; post-reset scrub state machine.
- Sits between core-side requesters and local scratch storage; single clock domain.

---
 rtl/mem_bank_nrw.sv | 153 +++++++++++++++
 tb/tb_mem_bank_nrw.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_nrw.sv
// N-port read/write register-file bank: byte-masked writes, lowest-port-wins
// collision arbitration, registered reads, post-reset scrub.
// Optional MEM_BANK_NRW_BYPASS_EN: same-cycle reads return the newly written value.

module mem_bank_nrw_port #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_fire_i,
  input  logic [WIDTH-1:0] rd_data_i,
  input  logic             drop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             drop_o
);
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q, drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      rvalid_q <= rd_fire_i;
      drop_q   <= drop_i;
      if (rd_fire_i) rdata_q <= rd_data_i;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign drop_o   = drop_q;
endmodule

module mem_bank_nrw #(
  parameter int               NUM_PORTS  = 2,
  parameter int               WIDTH      = 64,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           RW_en,
  input  logic [NUM_PORTS-1:0]           RW_wmode,
  input  logic [NUM_PORTS*AW-1:0]        RW_addr,
  input  logic [NUM_PORTS*WIDTH-1:0]     RW_wdata,
  input  logic [NUM_PORTS*WIDTH/8-1:0]   RW_wmask,
  output logic [NUM_PORTS*WIDTH-1:0]     RW_rdata,
  output logic [NUM_PORTS-1:0]           RW_rvalid,
  output logic [NUM_PORTS-1:0]           wr_drop,
  output logic                           ready
);
  localparam int             NB      = WIDTH / 8;
  localparam logic [AW:0]    DEPTH_W = DEPTH[AW:0];
  localparam logic [AW-1:0]  LAST    = AW'(DEPTH - 1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t  state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          scrub;

  logic [NUM_PORTS-1:0][AW-1:0]    addr;
  logic [NUM_PORTS-1:0][WIDTH-1:0] wdata;
  logic [NUM_PORTS-1:0][NB-1:0]    wmask;
  logic [NUM_PORTS-1:0][WIDTH-1:0] rd_val;
  logic [NUM_PORTS-1:0]            in_rng, wr_req, wr_win, rd_fire, drop;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign addr  = RW_addr;
  assign wdata = RW_wdata;
  assign wmask = RW_wmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST) begin
        state_d = S_READY;
        ptr_d   = '0;
      end
    end
  end

  always_comb begin
    ready = (state_q == S_READY);
    scrub = (state_q == S_INIT);
  end

  // A higher-index write loses to any lower port writing the same in-range address.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_rng[p]  = ({1'b0, addr[p]} < DEPTH_W);
      wr_req[p]  = ready && RW_en[p] && RW_wmode[p] && in_rng[p];
      rd_fire[p] = ready && RW_en[p] && !RW_wmode[p];
    end
    wr_win = wr_req;
    for (int p = 1; p < NUM_PORTS; p++)
      for (int q = 0; q < p; q++)
        if (wr_req[q] && (addr[q] == addr[p])) wr_win[p] = 1'b0;
    drop = wr_req & ~wr_win;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (scrub) begin
      mem_d[ptr_q] = INIT_VALUE;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (wr_win[p])
          for (int b = 0; b < NB; b++)
            if (wmask[p][b]) mem_d[addr[p]][b*8 +: 8] = wdata[p][b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
`ifdef MEM_BANK_NRW_BYPASS_EN
    assign rd_val[p] = in_rng[p] ? mem_d[addr[p]] : '0;
`else
    assign rd_val[p] = in_rng[p] ? mem_q[addr[p]] : '0;
`endif
    mem_bank_nrw_port #(.WIDTH(WIDTH)) u_port (
      .clk      (clk),
      .rst      (rst),
      .rd_fire_i(rd_fire[p]),
      .rd_data_i(rd_val[p]),
      .drop_i   (drop[p]),
      .rdata_o  (RW_rdata[p*WIDTH +: WIDTH]),
      .rvalid_o (RW_rvalid[p]),
      .drop_o   (wr_drop[p])
    );
  end
endmodule

// File: tb/tb_mem_bank_nrw.sv
// Directed bench for mem_bank_nrw (4 ports, 5 entries) with a per-cycle
// reference model plus literal expectations at key points.
module tb_mem_bank_nrw;
  localparam int NP = 4;
  localparam int W  = 64;
  localparam int D  = 5;
  localparam int AW = 3;
  localparam int MW = W / 8;
  localparam int CW = NP * W;
  localparam logic [W-1:0] INIT = '0;
`ifdef MEM_BANK_NRW_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef logic [CW-1:0] cv_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NP-1:0]  en, wm, rvalid, drop;
  logic [NP*AW-1:0] addr;
  logic [NP*W-1:0]  wdata, rdata;
  logic [NP*MW-1:0] wmask;
  logic           ready;

  int  ntests = 0;
  int  nfail  = 0;
  bit  chk_en = 1'b0;

  mem_bank_nrw #(.NUM_PORTS(NP), .WIDTH(W), .DEPTH(D), .INIT_VALUE(INIT)) dut (
    .clk(clk), .rst(rst), .RW_en(en), .RW_wmode(wm), .RW_addr(addr),
    .RW_wdata(wdata), .RW_wmask(wmask), .RW_rdata(rdata), .RW_rvalid(rvalid),
    .wr_drop(drop), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input cv_t act, input cv_t exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: scrub counter, byte array, per-address winner search.
  logic [W-1:0] mm [D];
  logic [W-1:0] old [D];
  int           mptr;
  bit           mready;
  logic [NP-1:0] e_rv, e_dr;
  logic [NP*W-1:0] e_rd;

  always @(posedge clk) begin
    if (rst) begin
      mptr = 0; mready = 0; e_rv = '0; e_dr = '0; e_rd = '0;
    end else if (!mready) begin
      mm[mptr] = INIT;
      mptr++;
      if (mptr == D) mready = 1;
      e_rv = '0; e_dr = '0;
    end else begin
      for (int i = 0; i < D; i++) old[i] = mm[i];
      e_rv = '0; e_dr = '0;
      for (int a = 0; a < D; a++) begin
        int win;
        win = -1;
        for (int p = 0; p < NP; p++)
          if (en[p] && wm[p] && int'(addr[p*AW +: AW]) == a) begin
            if (win < 0) win = p;
            else e_dr[p] = 1'b1;
          end
        if (win >= 0)
          for (int b = 0; b < MW; b++)
            if (wmask[win*MW + b]) mm[a][b*8 +: 8] = wdata[win*W + b*8 +: 8];
      end
      for (int p = 0; p < NP; p++)
        if (en[p] && !wm[p]) begin
          int a;
          a = int'(addr[p*AW +: AW]);
          e_rv[p] = 1'b1;
          if (a >= D) e_rd[p*W +: W] = '0;
          else e_rd[p*W +: W] = BYP ? mm[a] : old[a];
        end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_rdata",  cv_t'(rdata),  cv_t'(e_rd));
      chk("mdl_rvalid", cv_t'(rvalid), cv_t'(e_rv));
      chk("mdl_drop",   cv_t'(drop),   cv_t'(e_dr));
      chk("mdl_ready",  cv_t'(ready),  cv_t'(mready));
    end
  end

  task automatic idle();
    en = '0; wm = '0; addr = '0; wdata = '0; wmask = '0;
  endtask
  task automatic rd(input int p, input int a);
    en[p] = 1'b1; wm[p] = 1'b0; addr[p*AW +: AW] = AW'(a);
  endtask
  task automatic wr(input int p, input int a, input logic [W-1:0] d, input logic [MW-1:0] m);
    en[p] = 1'b1; wm[p] = 1'b1; addr[p*AW +: AW] = AW'(a);
    wdata[p*W +: W] = d; wmask[p*MW +: MW] = m;
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  function automatic logic [W-1:0] rdp(input int p);
    return rdata[p*W +: W];
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) tick();
    chk_en = 1'b1;
    chk("rst_ready",  cv_t'(ready),  cv_t'(0));
    chk("rst_rvalid", cv_t'(rvalid), cv_t'(0));
    chk("rst_rdata",  cv_t'(rdata),  cv_t'(0));

    // Scrub: a write is offered but must be ignored.
    rst = 1'b0;
    wr(0, 1, '1, '1);
    for (int c = 1; c <= D; c++) begin
      tick();
      if (c == 4) idle();
      chk("scrub_ready", cv_t'(ready), cv_t'(c == D));
      chk("scrub_rvalid", cv_t'(rvalid), cv_t'(0));
    end

    rd(0, 0); rd(1, 1); rd(2, 2); rd(3, 3);
    tick(); idle();
    chk("init_rd_all", cv_t'(rdata), cv_t'(0));
    chk("init_rvalid", cv_t'(rvalid), cv_t'(4'b1111));
    rd(0, 4);
    tick(); idle();
    chk("init_rd4", cv_t'(rdp(0)), cv_t'(0));

    wr(0, 1, 64'h1122334455667788, 8'hFF);
    tick(); idle();
    chk("wr_rvalid", cv_t'(rvalid), cv_t'(0));
    wr(0, 1, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    tick(); idle();
    rd(1, 1);
    tick(); idle();
    chk("mask_merge", cv_t'(rdp(1)), cv_t'(64'h11223344AAAAAAAA));
    rd(0, 1); rd(1, 1); rd(2, 1); rd(3, 1);
    tick(); idle();
    chk("same_addr_p3", cv_t'(rdp(3)), cv_t'(64'h11223344AAAAAAAA));

    wr(0, 2, 64'h5, 8'hFF); wr(1, 2, 64'h9, 8'hFF);
    tick(); idle();
    chk("coll_drop", cv_t'(drop), cv_t'(4'b0010));
    rd(0, 2);
    tick(); idle();
    chk("coll_drop_pulse", cv_t'(drop), cv_t'(0));
    chk("coll_winner", cv_t'(rdp(0)), cv_t'(64'h5));

    wr(0, 3, 64'h7, 8'hFF); wr(1, 0, 64'hA1, 8'hFF);
    wr(2, 0, 64'hA2, 8'hFF); wr(3, 0, 64'hA3, 8'hFF);
    tick(); idle();
    chk("coll3_drop", cv_t'(drop), cv_t'(4'b1100));
    rd(2, 0);
    tick(); idle();
    chk("coll3_winner", cv_t'(rdp(2)), cv_t'(64'hA1));

    wr(0, 3, 64'hC, 8'hFF); rd(1, 3);
    tick(); idle();
    chk("rdw", cv_t'(rdp(1)), cv_t'(BYP ? 64'hC : 64'h7));
    rd(2, 3);
    tick(); idle();
    chk("rdw_after", cv_t'(rdp(2)), cv_t'(64'hC));

    wr(0, 6, 64'hDEAD, 8'hFF); wr(2, 6, 64'hBEEF, 8'hFF);
    wr(1, 4, '1, 8'h00); rd(3, 6);
    tick(); idle();
    chk("oor_rdata",  cv_t'(rdp(3)), cv_t'(0));
    chk("oor_rvalid", cv_t'(rvalid), cv_t'(4'b1000));
    chk("oor_drop",   cv_t'(drop), cv_t'(0));
    rd(0, 4); rd(1, 0); rd(2, 2); rd(3, 3);
    tick(); idle();
    chk("mask0_noop", cv_t'(rdp(0)), cv_t'(0));
    tick();
    chk("hold_rdata",  cv_t'(rdp(3)), cv_t'(64'hC));
    chk("hold_rvalid", cv_t'(rvalid), cv_t'(0));

    // One-cycle reset in the middle of traffic.
    rd(0, 1); rd(1, 2); wr(2, 0, 64'h77, 8'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0; idle();
    chk("mrst_rvalid", cv_t'(rvalid), cv_t'(0));
    chk("mrst_ready",  cv_t'(ready), cv_t'(0));
    chk("mrst_rdata",  cv_t'(rdata), cv_t'(0));
    for (int c = 1; c <= D; c++) begin
      tick();
      chk("rescrub_ready", cv_t'(ready), cv_t'(c == D));
    end
    rd(0, 0); rd(1, 1); rd(2, 2); rd(3, 3);
    tick(); idle();
    chk("rescrub_rd", cv_t'(rdata), cv_t'({NP{INIT}}));
    rd(0, 4);
    tick(); idle();
    chk("rescrub_rd4", cv_t'(rdp(0)), cv_t'(INIT));
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
